// File: rtl/da_out_quant.sv
// da_out_quant: output quantiser for the da stage.
// Two-stage pipeline (S1 capture, S2 shift/round/saturate) feeding a small
// first-word-fall-through FIFO. Inputs that cannot be guaranteed a FIFO slot
// are dropped at S1 entry and counted in a saturating drop counter.
// Optional build macro: DA_OUT_ROUND_EN adds round-half-up before the shift;
// without it the shift truncates toward -infinity and S2 has no adder.
module da_out_quant #(
  parameter int SHIFT = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic signed [37:0] acc_in,
  input  logic               acc_valid,
  output logic signed [15:0] dout,
  output logic               dout_sat,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [7:0]         drop_cnt,
  output logic [4:0]         level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] DEPTH_W = 6'(DEPTH);
  localparam logic signed [38:0] SAT_HI = 39'sd32767;
  localparam logic signed [38:0] SAT_LO = -39'sd32768;

  logic               s1_valid;
  logic signed [37:0] s1_data;
  logic               s2_valid;
  logic [15:0]        s2_word;
  logic               s2_sat;

  logic [5:0]         occupancy;
  logic               accept;
  logic               drop;

  logic signed [38:0] ext;
  logic signed [38:0] rounded;
  logic signed [38:0] shifted;
  logic [15:0]        q_word;
  logic               q_sat;

  logic [16:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push;
  logic               pop;
  logic [16:0]        head;

  // Admission: a word enters S1 only if a FIFO slot is already reserved for it,
  // counting stored words plus everything still in the pipeline.
  always_comb begin
    occupancy = {1'b0, level} + {5'b0, s1_valid} + {5'b0, s2_valid};
    accept    = acc_valid && (occupancy < DEPTH_W);
    drop      = acc_valid && !accept;
  end

  // S1: capture the accumulator word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_data <= acc_in;
    end
  end

  assign ext = {s1_data[37], s1_data};

`ifdef DA_OUT_ROUND_EN
  localparam logic signed [38:0] ROUND_K = 39'sd1 <<< (SHIFT - 1);
  // The 39-bit headroom absorbs the rounding constant for any 38-bit input.
  assign rounded = ext + ROUND_K;
`else
  assign rounded = ext;
`endif

  assign shifted = rounded >>> SHIFT;

  // Clamp the shifted value into the signed 16-bit output range.
  always_comb begin
    q_sat  = 1'b0;
    q_word = shifted[15:0];
    if (shifted > SAT_HI) begin
      q_sat  = 1'b1;
      q_word = 16'h7FFF;
    end else if (shifted < SAT_LO) begin
      q_sat  = 1'b1;
      q_word = 16'h8000;
    end
  end

  // S2: register the quantised word and its saturation flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_word  <= '0;
      s2_sat   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_word <= q_word;
        s2_sat  <= q_sat;
      end
    end
  end

  // Admission already reserved a slot, so an S2 word can always be written.
  assign push = s2_valid;
  assign pop  = dout_valid && dout_ready;

  // FIFO storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {s2_sat, s2_word};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy tracking; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  // Dropped-sample counter, holds at 255.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign head       = mem[rd_ptr];
  assign dout       = signed'(head[15:0]);
  assign dout_sat   = head[16];
  assign dout_valid = (level != 5'd0);

endmodule

// File: tb/tb_da_out_quant.sv
// Self-checking bench for da_out_quant (SHIFT=16, DEPTH=4).
module tb_da_out_quant;

  localparam int SHIFT = 16;
  localparam int DEPTH = 4;

  logic               clk;
  logic               resetn;
  logic signed [37:0] acc_in;
  logic               acc_valid;
  logic signed [15:0] dout;
  logic               dout_sat;
  logic               dout_valid;
  logic               dout_ready;
  logic [7:0]         drop_cnt;
  logic [4:0]         level;

  int errors = 0;
  int checks = 0;

  da_out_quant #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .acc_in     (acc_in),
    .acc_valid  (acc_valid),
    .dout       (dout),
    .dout_sat   (dout_sat),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .drop_cnt   (drop_cnt),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words accepted at edge c appear in the FIFO at edge c+2.
  typedef struct {
    logic [16:0] word;
    int          due;
  } pipe_t;

  pipe_t       pipe[$];
  logic [16:0] exp_q[$];
  int          m_drop = 0;
  int          cyc = 0;

  function automatic logic [16:0] model_quant(input logic [37:0] a);
    longint v;
    longint q;
    v = longint'($signed(a));
`ifdef DA_OUT_ROUND_EN
    v = v + (64'sd1 <<< (SHIFT - 1));
`endif
    q = v >>> SHIFT;
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  task automatic model_clear();
    pipe.delete();
    exp_q.delete();
    m_drop = 0;
  endtask

  // Apply one cycle of inputs, clock it, advance the model, settle 1 unit.
  task automatic drive_edge(input bit v, input logic [37:0] d, input bit r);
    int qs;
    int ps;
    bit do_pop;
    bit do_acc;
    pipe_t e;
    acc_valid  = v;
    acc_in     = d;
    dout_ready = r;
    @(posedge clk);
    cyc++;
    qs = exp_q.size();
    ps = pipe.size();
    do_pop = (qs > 0) && r;
    do_acc = v && (qs + ps < DEPTH);
    if (v && !do_acc && m_drop < 255) m_drop++;
    if (do_pop) void'(exp_q.pop_front());
    while (pipe.size() > 0 && pipe[0].due == cyc) begin
      e = pipe.pop_front();
      exp_q.push_back(e.word);
    end
    if (do_acc) begin
      e.word = model_quant(d);
      e.due  = cyc + 2;
      pipe.push_back(e);
    end
    #1;
  endtask

  task automatic apply_reset();
    acc_valid  = 1'b0;
    acc_in     = '0;
    dout_ready = 1'b0;
    resetn     = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    acc_valid  = 1'b0;
    acc_in     = '0;
    dout_ready = 1'b0;
    resetn     = 1'b0;
    #3;
    checks++;
    if (dout_valid !== 1'b0 || level !== 5'd0 || drop_cnt !== 8'd0 ||
        dout !== 16'sd0 || dout_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b level=%0d drop=%0d dout=%h sat=%b, want all zero",
               dout_valid, level, drop_cnt, dout, dout_sat);
    end
    apply_reset();
  endtask

  task automatic test_quant_directed();
    logic [15:0] exp_a;
    logic [15:0] exp_b;
`ifdef DA_OUT_ROUND_EN
    exp_a = 16'd19;
    exp_b = 16'h0000;
`else
    exp_a = 16'd18;
    exp_b = 16'hFFFF;
`endif
    apply_reset();
    drive_edge(1'b1, 38'h0000128000, 1'b1);
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n: dout_valid=%b want 0", dout_valid);
    end
    drive_edge(1'b1, 38'h3FFFFFFFFF, 1'b1);
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1: dout_valid=%b want 0", dout_valid);
    end
    drive_edge(1'b1, 38'h1000000000, 1'b1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== exp_a || dout_sat !== 1'b0) begin
      errors++;
      $display("FAIL quant_128000: valid=%b dout=%h sat=%b want 1 %h 0",
               dout_valid, dout, dout_sat, exp_a);
    end
    drive_edge(1'b1, 38'h3000000000, 1'b1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== exp_b || dout_sat !== 1'b0 || level !== 5'd1) begin
      errors++;
      $display("FAIL quant_minus1: valid=%b dout=%h sat=%b level=%0d want 1 %h 0 1",
               dout_valid, dout, dout_sat, level, exp_b);
    end
    drive_edge(1'b0, '0, 1'b1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'h7FFF || dout_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos: valid=%b dout=%h sat=%b want 1 7fff 1", dout_valid, dout, dout_sat);
    end
    drive_edge(1'b0, '0, 1'b1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'h8000 || dout_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg: valid=%b dout=%h sat=%b want 1 8000 1", dout_valid, dout, dout_sat);
    end
    drive_edge(1'b0, '0, 1'b1);
    checks++;
    if (dout_valid !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b level=%0d want 0 0", dout_valid, level);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int k = 1; k <= 6; k++) drive_edge(1'b1, 38'(k) << 16, 1'b0);
    repeat (2) drive_edge(1'b0, '0, 1'b0);
    checks++;
    if (level !== 5'd4 || drop_cnt !== 8'd2 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_fill: level=%0d drop=%0d valid=%b want 4 2 1", level, drop_cnt, dout_valid);
    end
    // Held head must stay put while not ready.
    drive_edge(1'b1, 38'(9) << 16, 1'b0);
    checks++;
    if (dout !== 16'sd1 || dout_sat !== 1'b0 || drop_cnt !== 8'd3) begin
      errors++;
      $display("FAIL bp_hold: dout=%0d sat=%b drop=%0d want 1 0 3", dout, dout_sat, drop_cnt);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 16'(k)) begin
        errors++;
        $display("FAIL bp_order_%0d: valid=%b dout=%0d want 1 %0d", k, dout_valid, dout, k);
      end
      drive_edge(1'b0, '0, 1'b1);
    end
    checks++;
    if (dout_valid !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b level=%0d want 0 0", dout_valid, level);
    end
  endtask

  task automatic test_drop_saturate();
    apply_reset();
    for (int i = 1; i <= 300; i++) begin
      drive_edge(1'b1, 38'($urandom), 1'b0);
      if (i == 258) begin
        checks++;
        if (drop_cnt !== 8'd254) begin
          errors++;
          $display("FAIL drop_258: drop=%0d want 254", drop_cnt);
        end
      end
      if (i == 259) begin
        checks++;
        if (drop_cnt !== 8'd255) begin
          errors++;
          $display("FAIL drop_259: drop=%0d want 255", drop_cnt);
        end
      end
    end
    checks++;
    if (drop_cnt !== 8'd255 || level !== 5'd4) begin
      errors++;
      $display("FAIL drop_hold: drop=%0d level=%0d want 255 4", drop_cnt, level);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 1; k <= 6; k++) drive_edge(1'b1, 38'(k) << 16, 1'b0);
    repeat (2) drive_edge(1'b0, '0, 1'b0);
    drive_edge(1'b0, '0, 1'b1);
    checks++;
    if (level !== 5'd3 || drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL ar_setup: level=%0d drop=%0d want 3 2", level, drop_cnt);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || level !== 5'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ar_immediate: valid=%b level=%0d drop=%0d want 0 0 0",
               dout_valid, level, drop_cnt);
    end
    apply_reset();
    drive_edge(1'b1, 38'(5) << 16, 1'b1);
    drive_edge(1'b0, '0, 1'b1);
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_latency_early: valid=%b want 0", dout_valid);
    end
    drive_edge(1'b0, '0, 1'b1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'sd5) begin
      errors++;
      $display("FAIL ar_latency: valid=%b dout=%0d want 1 5", dout_valid, dout);
    end
    drive_edge(1'b0, '0, 1'b1);
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_one_cycle: valid=%b want 0", dout_valid);
    end
  endtask

  task automatic test_random();
    longint bnd [6];
    longint val;
    bit v;
    bit r;
    int ready_bias;
    bnd[0] = 64'sh7FFF_FFFF;
    bnd[1] = 64'sh8000_0000;
    bnd[2] = -64'sh8000_0000;
    bnd[3] = -64'sh8000_0001;
    bnd[4] = 64'sh7FFF_8000;
    bnd[5] = 64'sh7FFF_7FFF;
    apply_reset();
    for (int i = 0; i < 700; i++) begin
      ready_bias = ((i / 50) % 2 == 0) ? 3 : 1;
      case ($urandom_range(0, 3))
        0:       val = longint'($urandom_range(0, 2097151)) - 64'sd1048576;
        1:       val = longint'(int'($urandom));
        2:       val = longint'({$urandom, $urandom});
        default: val = bnd[$urandom_range(0, 5)];
      endcase
      v = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 3) < ready_bias);
      drive_edge(v, val[37:0], r);
      checks++;
      if (level !== 5'(exp_q.size()) || dout_valid !== (exp_q.size() > 0) ||
          drop_cnt !== 8'(m_drop)) begin
        errors++;
        $display("FAIL rand_state@%0d: level=%0d valid=%b drop=%0d want %0d %b %0d",
                 i, level, dout_valid, drop_cnt, exp_q.size(), exp_q.size() > 0, m_drop);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if ({dout_sat, dout} !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_data@%0d: sat=%b dout=%h want sat=%b dout=%h",
                   i, dout_sat, dout, exp_q[0][16], exp_q[0][15:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_quant_directed();
    test_backpressure();
    test_drop_saturate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
